axi_burst_master: RTL and testbench

AXI_BURST_MASTER -- requirements
Module: axi_burst_master

---
 rtl/axi_burst_master_if.sv | 56 +++++
 rtl/axi_burst_master.sv | 178 +++++++++++++++++
 tb/tb_axi_burst_master.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/axi_burst_master_if.sv
// AXI bus payload types and the initiator/responder interface used by axi_burst_master.
// Struct field widths are fixed here; instantiate the master with matching width parameters.
package axi_burst_master_pkg;

    localparam int unsigned AXI_IDW_W  = 4;
    localparam int unsigned AXI_IDR_W  = 4;
    localparam int unsigned AXI_ADDR_W = 4;
    localparam int unsigned AXI_DATA_W = 32;
    localparam int unsigned AXI_STRB_W = AXI_DATA_W / 8;

    typedef struct packed {
        logic [AXI_IDW_W-1:0]  awid;
        logic [AXI_ADDR_W-1:0] awaddr;
        logic [7:0]            awlen;
        logic [2:0]            awsize;
        logic [1:0]            awburst;
        logic                  awvalid;
        logic [AXI_DATA_W-1:0] wdata;
        logic [AXI_STRB_W-1:0] wstrb;
        logic                  wlast;
        logic                  wvalid;
        logic                  bready;
        logic [AXI_IDR_W-1:0]  arid;
        logic [AXI_ADDR_W-1:0] araddr;
        logic [7:0]            arlen;
        logic [2:0]            arsize;
        logic [1:0]            arburst;
        logic                  arvalid;
        logic                  rready;
    } axi_mosi_t;

    typedef struct packed {
        logic                  awready;
        logic                  wready;
        logic [AXI_IDW_W-1:0]  bid;
        logic [1:0]            bresp;
        logic                  bvalid;
        logic                  arready;
        logic [AXI_IDR_W-1:0]  rid;
        logic [AXI_DATA_W-1:0] rdata;
        logic [1:0]            rresp;
        logic                  rlast;
        logic                  rvalid;
    } axi_miso_t;

endpackage

interface axi_burst_master_if;
    import axi_burst_master_pkg::*;

    axi_mosi_t out_mosi_o;
    axi_miso_t out_miso_i;

    modport master (output out_mosi_o, input out_miso_i);
    modport slave  (input out_mosi_o, output out_miso_i);
endinterface

// File: rtl/axi_burst_master.sv
// Single-outstanding AXI burst master: one command becomes one AW/W/B or AR/R transaction.
// W and R beats pass straight through between the local beat ports and the AXI bus.
module axi_burst_master
    import axi_burst_master_pkg::*;
#(
    parameter int unsigned ID_W_WIDTH     = 4,
    parameter int unsigned ID_R_WIDTH     = 4,
    parameter int unsigned ADDR_WIDTH     = 4,
    parameter int unsigned AXI_DATA_WIDTH = 32,
    parameter int unsigned BYTE_WIDTH     = 8,
    parameter int unsigned BATCH_WIDTH    = AXI_DATA_WIDTH / BYTE_WIDTH,
    parameter int unsigned MASTER_ID      = 0
) (
    input  logic                      clk_i,
    input  logic                      rst_n_i,
    input  logic                      cmd_valid_i,
    output logic                      cmd_ready_o,
    input  logic                      cmd_write_i,
    input  logic [ADDR_WIDTH-1:0]     cmd_addr_i,
    input  logic [7:0]                cmd_len_i,
    input  logic [1:0]                cmd_burst_i,
    input  logic                      wr_valid_i,
    output logic                      wr_ready_o,
    input  logic [AXI_DATA_WIDTH-1:0] wr_data_i,
    input  logic [BATCH_WIDTH-1:0]    wr_strb_i,
    output logic                      rd_valid_o,
    input  logic                      rd_ready_i,
    output logic [AXI_DATA_WIDTH-1:0] rd_data_o,
    output logic                      rd_last_o,
    output logic                      done_o,
    output logic [1:0]                resp_o,
    axi_burst_master_if.master        axi
);

    localparam logic [ID_W_WIDTH-1:0] AW_ID   = ID_W_WIDTH'(MASTER_ID);
    localparam logic [ID_R_WIDTH-1:0] AR_ID   = ID_R_WIDTH'(MASTER_ID);
    localparam logic [2:0]            AX_SIZE = 3'($clog2(BATCH_WIDTH));
    localparam logic [1:0]            OKAY    = 2'b00;

    typedef enum logic [2:0] {IDLE, AW, W, B, AR, R} state_e;

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [7:0]              len_q;
    logic [1:0]              burst_q;
    logic [7:0]              beat_q;
    logic                    err_q;
    logic [1:0]              code_q;
    logic [1:0]              resp_q;

    logic                    capture;
    logic                    w_hs;
    logic                    r_hs;
    logic                    wlast;
    axi_mosi_t               mosi;
    axi_miso_t               miso;

    assign miso  = axi.out_miso_i;
    assign wlast = (beat_q == len_q);

    // State register
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // Next state, handshake gating and bus outputs
    always_comb begin
        state_d     = state_q;
        cmd_ready_o = 1'b0;
        wr_ready_o  = 1'b0;
        rd_valid_o  = 1'b0;
        done_o      = 1'b0;
        resp_o      = resp_q;
        capture     = 1'b0;
        w_hs        = 1'b0;
        r_hs        = 1'b0;

        mosi         = '0;
        mosi.awid    = AXI_IDW_W'(AW_ID);
        mosi.awaddr  = AXI_ADDR_W'(addr_q);
        mosi.awlen   = len_q;
        mosi.awsize  = AX_SIZE;
        mosi.awburst = burst_q;
        mosi.wdata   = AXI_DATA_W'(wr_data_i);
        mosi.wstrb   = AXI_STRB_W'(wr_strb_i);
        mosi.wlast   = wlast;
        mosi.arid    = AXI_IDR_W'(AR_ID);
        mosi.araddr  = AXI_ADDR_W'(addr_q);
        mosi.arlen   = len_q;
        mosi.arsize  = AX_SIZE;
        mosi.arburst = burst_q;

        unique case (state_q)
            IDLE: begin
                cmd_ready_o = 1'b1;
                if (cmd_valid_i) begin
                    capture = 1'b1;
                    state_d = cmd_write_i ? AW : AR;
                end
            end
            AW: begin
                mosi.awvalid = 1'b1;
                if (miso.awready) state_d = W;
            end
            W: begin
                mosi.wvalid = wr_valid_i;
                wr_ready_o  = miso.wready;
                if (wr_valid_i && miso.wready) begin
                    w_hs = 1'b1;
                    if (wlast) state_d = B;
                end
            end
            B: begin
                mosi.bready = 1'b1;
                if (miso.bvalid) begin
                    done_o  = 1'b1;
                    resp_o  = miso.bresp;
                    state_d = IDLE;
                end
            end
            AR: begin
                mosi.arvalid = 1'b1;
                if (miso.arready) state_d = R;
            end
            R: begin
                rd_valid_o  = miso.rvalid;
                mosi.rready = rd_ready_i;
                if (miso.rvalid && rd_ready_i) begin
                    r_hs = 1'b1;
                    if (miso.rlast) begin
                        done_o  = 1'b1;
                        resp_o  = err_q ? code_q : miso.rresp;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Command capture, beat counting and response bookkeeping
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            addr_q  <= '0;
            len_q   <= '0;
            burst_q <= '0;
            beat_q  <= '0;
            err_q   <= 1'b0;
            code_q  <= OKAY;
            resp_q  <= OKAY;
        end else begin
            if (capture) begin
                addr_q  <= cmd_addr_i;
                len_q   <= cmd_len_i;
                burst_q <= cmd_burst_i;
                beat_q  <= '0;
                err_q   <= 1'b0;
                code_q  <= OKAY;
            end
            if (w_hs) beat_q <= beat_q + 8'd1;
            // Only the first error response of a read burst is kept
            if (r_hs && (miso.rresp != OKAY) && !err_q) begin
                err_q  <= 1'b1;
                code_q <= miso.rresp;
            end
            if (done_o) resp_q <= resp_o;
        end
    end

    assign axi.out_mosi_o = mosi;
    assign rd_data_o      = AXI_DATA_WIDTH'(miso.rdata);
    assign rd_last_o      = miso.rlast;

    logic unused_ids;
    assign unused_ids = ^{miso.bid, miso.rid};

endmodule

// File: tb/tb_axi_burst_master.sv
// Randomized bench for axi_burst_master: plays the AXI responder and the local beat
// source/sink, checking every cycle against a transaction-level expectation.
module tb_axi_burst_master;
    import axi_burst_master_pkg::*;

    localparam int unsigned MID = 5;

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic        cmd_valid_i, cmd_ready_o, cmd_write_i;
    logic [3:0]  cmd_addr_i;
    logic [7:0]  cmd_len_i;
    logic [1:0]  cmd_burst_i;
    logic        wr_valid_i, wr_ready_o;
    logic [31:0] wr_data_i;
    logic [3:0]  wr_strb_i;
    logic        rd_valid_o, rd_ready_i;
    logic [31:0] rd_data_o;
    logic        rd_last_o, done_o;
    logic [1:0]  resp_o;
    axi_miso_t   miso;

    axi_burst_master_if bus ();
    assign bus.out_miso_i = miso;

    axi_burst_master #(.MASTER_ID(MID)) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_write_i(cmd_write_i),
        .cmd_addr_i(cmd_addr_i), .cmd_len_i(cmd_len_i), .cmd_burst_i(cmd_burst_i),
        .wr_valid_i(wr_valid_i), .wr_ready_o(wr_ready_o), .wr_data_i(wr_data_i),
        .wr_strb_i(wr_strb_i), .rd_valid_o(rd_valid_o), .rd_ready_i(rd_ready_i),
        .rd_data_o(rd_data_o), .rd_last_o(rd_last_o), .done_o(done_o), .resp_o(resp_o),
        .axi(bus)
    );

    always #5 clk_i = ~clk_i;

    int          n_chk  = 0;
    int          n_pass = 0;
    logic [1:0]  last_resp = 2'b00;
    logic [1:0]  rresp_pat [256];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        else n_pass++;
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_awvalid"}, 32'(bus.out_mosi_o.awvalid), 0);
        chk({tag, "_wvalid"},  32'(bus.out_mosi_o.wvalid),  0);
        chk({tag, "_bready"},  32'(bus.out_mosi_o.bready),  0);
        chk({tag, "_arvalid"}, 32'(bus.out_mosi_o.arvalid), 0);
        chk({tag, "_rready"},  32'(bus.out_mosi_o.rready),  0);
        chk({tag, "_wr_ready"}, 32'(wr_ready_o), 0);
        chk({tag, "_rd_valid"}, 32'(rd_valid_o), 0);
        chk({tag, "_done"},     32'(done_o),     0);
    endtask

    // One transaction; abort >= 0 applies reset while write beat index abort is offered
    task automatic run_txn(input bit wr, input logic [3:0] addr, input logic [7:0] len,
                           input logic [1:0] burst, input int ax_dly, input int b_dly,
                           input bit rnd, input logic [1:0] bresp, input int abort);
        int         beat;
        int         guard;
        bit         v, r;
        logic [1:0] exp_resp;

        cmd_valid_i = 1'b1; cmd_write_i = wr; cmd_addr_i = addr;
        cmd_len_i = len; cmd_burst_i = burst;
        #1;
        chk("cmd_ready_idle", 32'(cmd_ready_o), 1);
        chk("resp_hold", 32'(resp_o), 32'(last_resp));
        chk("done_idle", 32'(done_o), 0);
        step();

        for (int c = 0; c <= ax_dly; c++) begin
            miso.awready = wr && (c == ax_dly);
            miso.arready = !wr && (c == ax_dly);
            #1;
            chk("cmd_ready_busy", 32'(cmd_ready_o), 0);
            if (wr) begin
                chk("awvalid", 32'(bus.out_mosi_o.awvalid), 1);
                chk("arvalid_wr", 32'(bus.out_mosi_o.arvalid), 0);
                chk("awaddr", 32'(bus.out_mosi_o.awaddr), 32'(addr));
                chk("awlen", 32'(bus.out_mosi_o.awlen), 32'(len));
                chk("awburst", 32'(bus.out_mosi_o.awburst), 32'(burst));
                chk("awsize", 32'(bus.out_mosi_o.awsize), 2);
                chk("awid", 32'(bus.out_mosi_o.awid), MID);
            end else begin
                chk("arvalid", 32'(bus.out_mosi_o.arvalid), 1);
                chk("awvalid_rd", 32'(bus.out_mosi_o.awvalid), 0);
                chk("araddr", 32'(bus.out_mosi_o.araddr), 32'(addr));
                chk("arlen", 32'(bus.out_mosi_o.arlen), 32'(len));
                chk("arburst", 32'(bus.out_mosi_o.arburst), 32'(burst));
                chk("arsize", 32'(bus.out_mosi_o.arsize), 2);
                chk("arid", 32'(bus.out_mosi_o.arid), MID);
            end
            step();
        end
        miso.awready = 1'b0; miso.arready = 1'b0;

        beat = 0; guard = 0;
        if (wr) begin
            while (beat <= int'(len)) begin
                v = rnd ? 1'($urandom) : 1'b1;
                r = rnd ? 1'($urandom) : 1'b1;
                wr_valid_i = v; miso.wready = r;
                wr_data_i = $urandom; wr_strb_i = 4'($urandom);
                #1;
                chk("w_awvalid", 32'(bus.out_mosi_o.awvalid), 0);
                chk("wvalid", 32'(bus.out_mosi_o.wvalid), 32'(v));
                chk("wr_ready", 32'(wr_ready_o), 32'(r));
                chk("wdata", bus.out_mosi_o.wdata, wr_data_i);
                chk("wstrb", 32'(bus.out_mosi_o.wstrb), 32'(wr_strb_i));
                chk("wlast", 32'(bus.out_mosi_o.wlast), 32'(beat == int'(len)));
                chk("w_done", 32'(done_o), 0);
                chk("w_cmd_ready", 32'(cmd_ready_o), 0);
                if (beat == abort) begin
                    rst_n_i = 1'b0;
                    #1;
                    chk_quiet("rst");
                    chk("rst_resp", 32'(resp_o), 0);
                    chk("rst_cmd_ready", 32'(cmd_ready_o), 1);
                    wr_valid_i = 1'b0; miso.wready = 1'b0; cmd_valid_i = 1'b0;
                    step();
                    step();
                    rst_n_i = 1'b1;
                    last_resp = 2'b00;
                    return;
                end
                step();
                if (v && r) beat++;
                if (++guard > 400) begin
                    chk("w_timeout", 1, 0);
                    return;
                end
            end
            // keep beats offered in B to prove no extra beat leaks out
            wr_valid_i = 1'b1; miso.wready = 1'b1;
            for (int c = 0; c <= b_dly; c++) begin
                miso.bvalid = (c == b_dly); miso.bresp = bresp;
                #1;
                chk("bready", 32'(bus.out_mosi_o.bready), 1);
                chk("b_wvalid", 32'(bus.out_mosi_o.wvalid), 0);
                chk("b_wr_ready", 32'(wr_ready_o), 0);
                chk("b_cmd_ready", 32'(cmd_ready_o), 0);
                chk("b_done", 32'(done_o), 32'(c == b_dly));
                if (c == b_dly) chk("b_resp", 32'(resp_o), 32'(bresp));
                step();
            end
            miso.bvalid = 1'b0; wr_valid_i = 1'b0; miso.wready = 1'b0;
            last_resp = bresp;
        end else begin
            exp_resp = 2'b00;
            for (int i = int'(len); i >= 0; i--)
                if (rresp_pat[i] != 2'b00) exp_resp = rresp_pat[i];
            while (beat <= int'(len)) begin
                v = rnd ? 1'($urandom) : 1'b1;
                r = rnd ? 1'($urandom) : 1'b1;
                miso.rvalid = v; rd_ready_i = r; miso.rdata = $urandom;
                miso.rresp = rresp_pat[beat]; miso.rlast = (beat == int'(len));
                #1;
                chk("rd_valid", 32'(rd_valid_o), 32'(v));
                chk("rready", 32'(bus.out_mosi_o.rready), 32'(r));
                chk("rd_data", rd_data_o, miso.rdata);
                chk("rd_last", 32'(rd_last_o), 32'(beat == int'(len)));
                chk("r_arvalid", 32'(bus.out_mosi_o.arvalid), 0);
                chk("r_cmd_ready", 32'(cmd_ready_o), 0);
                chk("r_done", 32'(done_o), 32'(v && r && beat == int'(len)));
                if (v && r && beat == int'(len)) chk("r_resp", 32'(resp_o), 32'(exp_resp));
                step();
                if (v && r) beat++;
                if (++guard > 400) begin
                    chk("r_timeout", 1, 0);
                    return;
                end
            end
            miso.rvalid = 1'b0; rd_ready_i = 1'b0; miso.rlast = 1'b0;
            last_resp = exp_resp;
        end
    endtask

    initial begin
        rst_n_i = 1'b0;
        cmd_valid_i = 1'b0; cmd_write_i = 1'b0; cmd_addr_i = '0; cmd_len_i = '0;
        cmd_burst_i = '0; wr_valid_i = 1'b0; wr_data_i = '0; wr_strb_i = '0;
        rd_ready_i = 1'b0; miso = '0;
        foreach (rresp_pat[i]) rresp_pat[i] = 2'b00;
        step();
        chk_quiet("reset");
        chk("reset_resp", 32'(resp_o), 0);
        chk("reset_cmd_ready", 32'(cmd_ready_o), 1);
        step();
        rst_n_i = 1'b1;

        // Directed: plain write, delayed single-beat read, read with an error beat
        run_txn(1'b1, 4'd4, 8'd3, 2'b01, 0, 0, 1'b0, 2'b00, -1);
        run_txn(1'b0, 4'd15, 8'd0, 2'b01, 3, 0, 1'b0, 2'b00, -1);
        rresp_pat[1] = 2'b10;
        run_txn(1'b0, 4'd2, 8'd2, 2'b01, 1, 0, 1'b0, 2'b00, -1);
        rresp_pat[1] = 2'b00;
        run_txn(1'b1, 4'd9, 8'd0, 2'b00, 0, 2, 1'b0, 2'b11, -1);
        run_txn(1'b1, 4'd6, 8'd3, 2'b01, 2, 1, 1'b1, 2'b10, -1);
        // Reset during the second of four write beats, then a read
        run_txn(1'b1, 4'd3, 8'd3, 2'b01, 0, 0, 1'b0, 2'b00, 1);
        run_txn(1'b0, 4'd7, 8'd1, 2'b10, 0, 0, 1'b0, 2'b00, -1);

        for (int t = 0; t < 40; t++) begin
            logic [7:0] len;
            len = 8'($urandom_range(7));
            for (int i = 0; i <= int'(len); i++)
                rresp_pat[i] = ($urandom_range(3) == 0) ? 2'($urandom_range(3, 1)) : 2'b00;
            run_txn(1'($urandom), 4'($urandom), len, 2'($urandom),
                    int'($urandom_range(3)), int'($urandom_range(2)), 1'b1, 2'($urandom), -1);
        end

        cmd_valid_i = 1'b0;
        #1;
        chk("final_cmd_ready", 32'(cmd_ready_o), 1);
        step();
        chk("final_resp_hold", 32'(resp_o), 32'(last_resp));
        chk("final_done", 32'(done_o), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
